reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/mips_pkg.sv | 32 +++
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/mdu_busy_counter.sv | 38 +++
 rtl/reg_scoreboard.sv | 110 +++++++++++
 tb/tb_reg_scoreboard.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings, latencies and pipeline-stage record for the register scoreboard.
// Also holds the small match helper used by forwarding and hazard detection.
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    localparam int unsigned MULT_LAT  = 5;
    localparam int unsigned DIV_LAT   = 32;
    localparam int unsigned MDU_CNT_W = $clog2(DIV_LAT + 1);

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } stage_t;

    localparam stage_t BUBBLE = '{dest: REG_ZERO, regwrite: 1'b0, memread: 1'b0};

    // r0 is hard-wired zero, so a producer targeting it never creates a dependency.
    function automatic logic stage_match(input stage_t s, input logic [4:0] r);
        return s.regwrite && (s.dest == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Bundle of the ID-stage request and scoreboard response signals.
// The driver side uses master, the scoreboard side uses slave.
interface reg_scoreboard_if;

    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dest;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_mdu_start;
    logic       id_mdu_div;
    logic       id_mf;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [4:0] wb_dest;
    logic       wb_regwrite;
    logic       mdu_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, id_mdu_start, id_mdu_div, id_mf, flush,
        input  stall, fwd_a, fwd_b, wb_dest, wb_regwrite, mdu_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, id_mdu_start, id_mdu_div, id_mf, flush,
        output stall, fwd_a, fwd_b, wb_dest, wb_regwrite, mdu_busy
    );

endinterface

// File: rtl/mdu_busy_counter.sv
// Down-counter tracking how long the HI/LO result of a mult/div is still pending.
// Loaded only by an accepted start; busy while the count is non-zero.
module mdu_busy_counter
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_LAT);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_LAT);

    logic [MDU_CNT_W-1:0] count_q;
    logic [MDU_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = div ? DIV_CNT : MULT_CNT;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// EX/MEM/WB destination scoreboard: operand forwarding selects, load-use and
// HI/LO interlocks, and the WB write-back destination.
module reg_scoreboard
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_dest,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_mdu_start,
    input  logic       id_mdu_div,
    input  logic       id_mf,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [4:0] wb_dest,
    output logic       wb_regwrite,
    output logic       mdu_busy
);

    stage_t ex_q;
    stage_t ex_d;
    stage_t mem_q;
    stage_t wb_q;

    logic [1:0][4:0] src;
    logic [1:0]      src_use;
    logic [1:0][1:0] fwd_sel;
    logic [1:0]      load_use_hit;

    logic load_use_stall;
    logic mdu_stall;
    logic id_accept;
    logic mdu_start_acc;

    assign src[0]     = id_rs;
    assign src[1]     = id_rt;
    assign src_use[0] = id_use_rs;
    assign src_use[1] = id_use_rt;

    // Operand 0 is rs (port A), operand 1 is rt (port B); nearest producer wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic m_ex;
            logic m_mem;
            logic m_wb;

            assign m_ex  = stage_match(ex_q,  src[gi]);
            assign m_mem = stage_match(mem_q, src[gi]);
            assign m_wb  = stage_match(wb_q,  src[gi]);

            assign fwd_sel[gi] = (m_ex && src_use[gi]) ? FWD_EX  :
                                 m_mem                  ? FWD_MEM :
                                 m_wb                   ? FWD_WB  : FWD_RF;

            assign load_use_hit[gi] = src_use[gi] && m_ex && ex_q.memread;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    assign load_use_stall = id_valid && (|load_use_hit);
    assign mdu_stall      = id_valid && (id_mf || id_mdu_start) && mdu_busy;
    assign stall          = load_use_stall || mdu_stall;

    assign id_accept     = id_valid && !stall && !flush;
    assign mdu_start_acc = id_accept && id_mdu_start;

    always_comb begin
        ex_d = BUBBLE;
        if (id_accept) begin
            ex_d.dest     = id_dest;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign wb_dest     = wb_q.dest;
    assign wb_regwrite = wb_q.regwrite;

    mdu_busy_counter u_mdu_busy_counter (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start_acc),
        .div   (id_mdu_div),
        .busy  (mdu_busy)
    );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard: forwarding, load-use, MDU interlock,
// flush and reset cases with hand-computed expectations.
module tb_reg_scoreboard;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (bus.id_valid),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_use_rs    (bus.id_use_rs),
        .id_use_rt    (bus.id_use_rt),
        .id_dest      (bus.id_dest),
        .id_regwrite  (bus.id_regwrite),
        .id_memread   (bus.id_memread),
        .id_mdu_start (bus.id_mdu_start),
        .id_mdu_div   (bus.id_mdu_div),
        .id_mf        (bus.id_mf),
        .flush        (bus.flush),
        .stall        (bus.stall),
        .fwd_a        (bus.fwd_a),
        .fwd_b        (bus.fwd_b),
        .wb_dest      (bus.wb_dest),
        .wb_regwrite  (bus.wb_regwrite),
        .mdu_busy     (bus.mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic mr, input logic ms, input logic md,
                         input logic mf, input logic fl);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_use_rs    = urs;
        bus.id_use_rt    = urt;
        bus.id_dest      = dest;
        bus.id_regwrite  = rw;
        bus.id_memread   = mr;
        bus.id_mdu_start = ms;
        bus.id_mdu_div   = md;
        bus.id_mf        = mf;
        bus.flush        = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) next();
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;

        // Reset state
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check_vec("rst_wb_regwrite", bus.wb_regwrite, 0);
        check_vec("rst_wb_dest",     bus.wb_dest, 0);
        check_vec("rst_mdu_busy",    bus.mdu_busy, 0);
        check_vec("rst_stall",       bus.stall, 0);
        check_vec("rst_fwd_a",       bus.fwd_a, FWD_RF);
        check_vec("rst_fwd_b",       bus.fwd_b, FWD_RF);

        // add r3, then consumers of r3 walk it through EX, MEM, WB
        next();
        drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0);
        next();
        drive(1, 5'd3, 0, 1, 0, 5'd4, 1, 0, 0, 0, 0, 0);
        settle();
        check_vec("ex_fwd_a",  bus.fwd_a, FWD_EX);
        check_vec("ex_stall",  bus.stall, 0);
        next();
        drive(1, 5'd3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_vec("mem_fwd_a", bus.fwd_a, FWD_MEM);
        next();
        settle();
        check_vec("wb_fwd_a",      bus.fwd_a, FWD_WB);
        check_vec("wb_dest_r3",    bus.wb_dest, 3);
        check_vec("wb_regwrite_r3", bus.wb_regwrite, 1);
        drain();

        // lw r5, then rt=5 consumer: one stall cycle, bubble, then MEM forward
        drive(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        next();
        drive(1, 0, 5'd5, 0, 1, 5'd6, 1, 0, 0, 0, 0, 0);
        settle();
        check_vec("lu_stall",     bus.stall, 1);
        check_vec("lu_fwd_b_ex",  bus.fwd_b, FWD_EX);
        next();
        settle();
        check_vec("lu_stall_one", bus.stall, 0);
        check_vec("lu_fwd_b_mem", bus.fwd_b, FWD_MEM);
        next();
        idle();
        settle();
        check_vec("lu_wb_dest",   bus.wb_dest, 5);
        check_vec("lu_wb_rw",     bus.wb_regwrite, 1);
        next();
        settle();
        check_vec("lu_bubble_rw", bus.wb_regwrite, 0);
        next();
        settle();
        check_vec("lu_cons_dest", bus.wb_dest, 6);
        drain();

        // load targeting r0, consumer reads r0 on both ports
        drive(1, 0, 0, 0, 0, REG_ZERO, 1, 1, 0, 0, 0, 0);
        next();
        drive(1, REG_ZERO, REG_ZERO, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_vec("r0_fwd_a", bus.fwd_a, FWD_RF);
        check_vec("r0_fwd_b", bus.fwd_b, FWD_RF);
        check_vec("r0_stall", bus.stall, 0);
        drain();

        // div accepted, mfhi immediately behind it
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        settle();
        check_vec("div_pre_busy", bus.mdu_busy, 0);
        next();
        drive(1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 1, 0);
        settle();
        check_vec("div_busy", bus.mdu_busy, 1);
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            next();
            settle();
        end
        check_vec("div_stall_cycles", n, 32);
        check_vec("div_busy_fall",    bus.mdu_busy, 0);
        check_vec("div_mf_accept",    bus.stall, 0);
        drain();

        // mult latency
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        next();
        idle();
        settle();
        n = 0;
        while (bus.mdu_busy && n < 40) begin
            n++;
            next();
            settle();
        end
        check_vec("mult_busy_cycles", n, 5);
        drain();

        // a mult start blocked behind a div must not reload the counter
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        next();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        check_vec("blk_stall", bus.stall, 1);
        next();
        idle();
        settle();
        n = 0;
        while (bus.mdu_busy && n < 40) begin
            n++;
            next();
            settle();
        end
        check_vec("blk_busy_left", n, 31);
        drain();

        // add r7, then jal (dest r31) flushed in ID->EX
        drive(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0);
        next();
        drive(1, 5'd7, 0, 1, 0, REG_RA, 1, 0, 0, 0, 0, 1);
        settle();
        check_vec("jal_fwd_a_r7", bus.fwd_a, FWD_EX);
        next();
        drive(1, REG_RA, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_vec("jal_no_fwd_r31", bus.fwd_a, FWD_RF);
        check_vec("jal_r7_mem",     bus.fwd_b, FWD_MEM);
        next();
        settle();
        check_vec("jal_no_fwd_mem", bus.fwd_a, FWD_RF);
        check_vec("jal_r7_wb",      bus.fwd_b, FWD_WB);
        drain();

        // reset at cycle 10 of a divide with mfhi waiting
        drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0);
        next();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        next();
        drive(1, 5'd9, 0, 1, 0, 5'd8, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i < 10; i++) next();
        settle();
        check_vec("mid_div_stall", bus.stall, 1);
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        check_vec("rst_div_busy",  bus.mdu_busy, 0);
        check_vec("rst_div_stall", bus.stall, 0);
        check_vec("rst_div_wb_rw", bus.wb_regwrite, 0);
        check_vec("rst_div_fwd_a", bus.fwd_a, FWD_RF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
